// File: rtl/serial_rx_os.sv
// Oversampling asynchronous serial receiver with optional parity, 1-2 stop bits and a held
// output frame. Define SERIAL_RX_SYNC_EN to add a 2-flop input synchronizer (2 cycles latency).
module serial_rx_os #(
  parameter int unsigned DATA_W      = 7,
  parameter bit          START_SIG   = 1'b0,
  parameter int unsigned OVERSAMPLE  = 4,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              s_in,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam bit          IdleLvl = ~START_SIG;
  localparam int unsigned CntW    = $clog2(OVERSAMPLE);
  localparam int unsigned BitW    = $clog2(DATA_W + 1);

  localparam logic [CntW-1:0] HalfCnt  = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] LastData = BitW'(DATA_W - 1);
  localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic s_r;

`ifdef SERIAL_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_q <= {2{IdleLvl}};
    end else begin
      sync_q <= {sync_q[0], s_in};
    end
  end

  assign s_r = sync_q[1];
`else
  assign s_r = s_in;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              done_q, done_d;
  logic              prev_q, prev_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              tick;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    done_d       = 1'b0;
    prev_d       = s_r;
    data_d       = data_q;
    valid_d      = valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;

    if (state_q != StIdle) begin
      cnt_d = tick ? FullCnt : cnt_q - CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (prev_q == IdleLvl && s_r == START_SIG) begin
          state_d = StStart;
          cnt_d   = HalfCnt;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_r == START_SIG) begin
            state_d = StData;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tick) begin
          // Shift right so the first received bit ends up in the LSB.
          shreg_d = (shreg_q >> 1) | (DATA_W'(s_r) << (DATA_W - 1));
          if (bit_q == LastData) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (tick) begin
          perr_d  = ((^shreg_q) ^ s_r) != (PARITY_MODE == 2);
          bit_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (tick) begin
          if (s_r != IdleLvl) begin
            ferr_d = 1'b1;
          end
          if (bit_q == LastStop) begin
            bit_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (valid_q && ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    // A finished frame loads only if the holding slot is free or being freed now.
    if (done_q) begin
      if (!valid_q || ready) begin
        data_d       = shreg_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_q;
        valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      done_q       <= 1'b0;
      prev_q       <= IdleLvl;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      done_q       <= done_d;
      prev_q       <= prev_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_rx_os.sv
// Self-checking bench for serial_rx_os: vector table, corner sequences and random frames.
module tb_serial_rx_os;

  localparam int unsigned DW   = 7;
  localparam int unsigned OS   = 4;
  localparam int unsigned PM   = 1;
  localparam int unsigned SB   = 1;
`ifdef SERIAL_RX_SYNC_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rstN;
  logic          s_in;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          parity_err;
  logic          frame_err;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  serial_rx_os #(
    .DATA_W     (DW),
    .START_SIG  (1'b0),
    .OVERSAMPLE (OS),
    .PARITY_MODE(PM),
    .STOP_BITS  (SB)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .s_in      (s_in),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid) vcount <= vcount + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          pbit;
    logic          stopv;
    logic [DW-1:0] ed;
    logic          ep;
    logic          ef;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Drives a whole frame; returns one cycle before the end of the last stop bit period,
  // i.e. just after the edge that samples the final stop bit.
  task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic stopv);
    logic line[$];
    line.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) line.push_back(d[i]);
    if (PM != 0) line.push_back(pbit);
    for (int i = 0; i < int'(SB); i++) line.push_back(stopv);
    foreach (line[k]) begin
      s_in = line[k];
      repeat ((k == line.size() - 1) ? OS - 1 : OS) tick();
    end
  endtask

  // Expected values from the frame content alone.
  task automatic expect_frame(input string tag, input logic [DW-1:0] d, input logic pbit,
                              input logic stopv);
    logic ep;
    logic ef;
    int   v0;
    ep = ((($countones(d) + int'(pbit)) % 2) == 1) != (PM == 2);
    ef = (stopv != 1'b1);
    chk({tag, "_valid_early"}, valid, 1'b0);
    v0 = vcount;
    repeat (1 + LAT) tick();
    chk({tag, "_valid"}, valid, 1'b1);
    chk({tag, "_data"}, data, d);
    chk({tag, "_perr"}, parity_err, ep);
    chk({tag, "_ferr"}, frame_err, ef);
    tick();
    chk({tag, "_pulse"}, vcount - v0, 1);
    chk({tag, "_valid_drop"}, valid, 1'b0);
  endtask

  task automatic idle(input int cycles);
    s_in = 1'b1;
    repeat (cycles) tick();
  endtask

  initial begin
    tbl[0] = '{d: 7'h55, pbit: 1'b0, stopv: 1'b1, ed: 7'h55, ep: 1'b0, ef: 1'b0};
    tbl[1] = '{d: 7'h55, pbit: 1'b1, stopv: 1'b1, ed: 7'h55, ep: 1'b1, ef: 1'b0};
    tbl[2] = '{d: 7'h2A, pbit: 1'b1, stopv: 1'b0, ed: 7'h2A, ep: 1'b0, ef: 1'b1};
    tbl[3] = '{d: 7'h2A, pbit: 1'b1, stopv: 1'b1, ed: 7'h2A, ep: 1'b0, ef: 1'b0};
    tbl[4] = '{d: 7'h7F, pbit: 1'b0, stopv: 1'b1, ed: 7'h7F, ep: 1'b1, ef: 1'b0};
    tbl[5] = '{d: 7'h00, pbit: 1'b0, stopv: 1'b0, ed: 7'h00, ep: 1'b0, ef: 1'b1};

    rstN  = 1'b0;
    s_in  = 1'b1;
    ready = 1'b1;
    repeat (2) tick();
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rstN = 1'b1;
    idle(6);

    // Table vectors with constant expectations.
    foreach (tbl[i]) begin
      int v0;
      send_frame(tbl[i].d, tbl[i].pbit, tbl[i].stopv);
      chk("tbl_valid_early", valid, 1'b0);
      v0 = vcount;
      repeat (1 + LAT) tick();
      chk("tbl_valid", valid, 1'b1);
      chk("tbl_data", data, tbl[i].ed);
      chk("tbl_perr", parity_err, tbl[i].ep);
      chk("tbl_ferr", frame_err, tbl[i].ef);
      tick();
      chk("tbl_pulse", vcount - v0, 1);
      idle(8);
    end

    // Overrun: hold ready low across two frames.
    ready = 1'b0;
    send_frame(7'h11, 1'b0, 1'b1);
    idle(6);
    send_frame(7'h22, 1'b0, 1'b1);
    idle(6);
    chk("ovr_valid", valid, 1'b1);
    chk("ovr_data", data, 7'h11);
    chk("ovr_flag", overrun, 1'b1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("ovr_valid_clr", valid, 1'b0);
    chk("ovr_flag_clr", overrun, 1'b0);
    ready = 1'b1;
    idle(4);

    // One-cycle glitch must not produce a frame.
    begin
      int v0;
      v0 = vcount;
      s_in = 1'b0;
      tick();
      idle(12);
      chk("glitch_nopulse", vcount - v0, 0);
      chk("glitch_valid", valid, 1'b0);
    end
    send_frame(7'h3C, 1'b0, 1'b1);
    expect_frame("post_glitch", 7'h3C, 1'b0, 1'b1);
    idle(6);

    // Reset in the middle of DATA with a held frame, line left at start level.
    ready = 1'b0;
    send_frame(7'h33, 1'b0, 1'b1);
    idle(6);
    chk("prerst_valid", valid, 1'b1);
    s_in = 1'b0;
    repeat (3 * OS) tick();
    rstN = 1'b0;
    #1;
    chk("midrst_data", data, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_perr", parity_err, 0);
    chk("midrst_ferr", frame_err, 0);
    chk("midrst_ovr", overrun, 0);
    tick();
    rstN  = 1'b1;
    ready = 1'b1;
    send_frame(7'h44, 1'b0, 1'b1);
    expect_frame("post_rst", 7'h44, 1'b0, 1'b1);
    idle(6);

    // Random frames against the content-level model.
    for (int n = 0; n < 20; n++) begin
      logic [DW-1:0] d;
      logic          pbit;
      logic          stopv;
      d     = DW'($urandom);
      pbit  = 1'($urandom_range(0, 1));
      stopv = ($urandom_range(0, 3) != 0);
      send_frame(d, pbit, stopv);
      expect_frame("rand", d, pbit, stopv);
      idle($urandom_range(4, 13));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx_os.md
SERIAL_RX_OS -- requirements
Module: serial_rx_os

Interface
REQ-001 SHALL have parameter DATA_W, default 7, number of data bits per frame (1..16).
REQ-002 SHALL have parameter START_SIG, default 0, line level of the start bit; idle/stop level is !START_SIG.
REQ-003 SHALL have parameter OVERSAMPLE, default 4, clk cycles per bit (even, 2..64).
REQ-004 SHALL have parameter PARITY_MODE, default 1, parity bit mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-006 SHALL have port clk, input, 1 bit, clock; all state changes on its rising edge.
REQ-007 SHALL have port rstN, input, 1 bit, reset; asynchronous, active-low.
REQ-008 SHALL have port s_in, input, 1 bit, serial line.
REQ-009 SHALL have port data, output, DATA_W bits, received word, LSB received first.
REQ-010 SHALL have port valid, output, 1 bit, data and flags hold a frame.
REQ-011 SHALL have port ready, input, 1 bit, consumer accepts the frame when valid && ready.
REQ-012 SHALL have port parity_err, output, 1 bit, parity mismatch for the held frame.
REQ-013 SHALL have port frame_err, output, 1 bit, bad stop bit for the held frame.
REQ-014 SHALL have port overrun, output, 1 bit, sticky flag: a frame was dropped.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE=0.
REQ-016 IDLE: on a sampled transition of s_in from !START_SIG to START_SIG, SHALL enter START with bit counter = OVERSAMPLE/2-1.
REQ-017 Every non-IDLE state SHALL decrement the counter each cycle and sample s_in when the counter is 0, then reload it with OVERSAMPLE-1.
REQ-018 START sample SHALL go to DATA if s_in==START_SIG; otherwise it is a glitch and the block SHALL return to IDLE with no output change.
REQ-019 DATA SHALL shift in DATA_W samples LSB first, then go to PARITY or STOP.
REQ-020 PARITY SHALL set parity_err_next = (XOR of data bits ^ sample) != (PARITY_MODE==2).
REQ-021 STOP SHALL take STOP_BITS samples; any sample != !START_SIG SHALL set frame_err_next; after the last sample the block SHALL return to IDLE.
REQ-022 The cycle after the last stop sample, if valid==0 or ready==1, SHALL load data, parity_err and frame_err and assert valid.
REQ-023 If valid==1 and ready==0 at that cycle, SHALL drop the new frame, keep the held frame, and set overrun.
REQ-024 valid SHALL clear the cycle after valid && ready unless a new frame loads in that same cycle (REQ-022); overrun SHALL clear on valid && ready.
REQ-025 Line activity SHALL NOT affect data or flags while valid is held.

Reset
REQ-026 While rstN=0: state=IDLE, data=0, valid=0, parity_err=0, frame_err=0, overrun=0, counters=0, last-sample register=!START_SIG.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release, a line already at START_SIG SHALL be detected as a start edge.

Configuration
REQ-028 Macro SERIAL_RX_SYNC_EN defined: s_in SHALL pass through a 2-flop synchronizer (reset to !START_SIG) before all logic, adding exactly 2 cycles of latency.
REQ-029 Macro SERIAL_RX_SYNC_EN undefined: s_in SHALL be used directly with no added latency.

Verification (defaults, macro undefined, ready=1 unless stated)
REQ-030 Send 7-bit 0x55 with parity 0 and one stop bit, 4 clk/bit -> valid pulses for 1 cycle 1 clk after the stop sample, data=0x55, parity_err=0, frame_err=0.
REQ-031 Send same frame with parity bit 1 -> data=0x55, parity_err=1.
REQ-032 Send 0x2A with stop bit = 0 -> data=0x2A, frame_err=1; next valid frame is received normally.
REQ-033 Hold ready=0, send 0x11 then 0x22 -> data stays 0x11, overrun=1; ready=1 for 1 cycle -> valid=0, overrun=0.
REQ-034 Pulse s_in low for 1 cycle -> no valid, state returns to IDLE; rstN low mid-DATA -> all outputs 0, next frame is received correctly.
REQ-035 With SERIAL_RX_SYNC_EN defined, repeat REQ-030 -> valid asserts exactly 2 cycles later.
